// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART on the processor IO bus.
// Transmit path: 4-entry byte FIFO feeding a serial shifter.
// Receive path: 2-flop synchroniser, mid-bit sampling, single holding register.
//
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-high reset
//   io_address      IO word address; bits [14:0] decoded against BASE_ADDR
//   io_write_value  store data
//   io_write_en     store strobe (one cycle)
//   io_read_en      load strobe; only gates the DATA-read side effect
//   io_read_value   combinational read data
//   uart_tx         registered serial output, idles high
//   uart_rx         serial input, asynchronous to clk
//
// Register map (word offsets from BASE_ADDR):
//   +0 DATA    write pushes [7:0] into the TX FIFO; read returns {8'h00, rx_data}
//   +1 STATUS  read  {10'b0, rx_frame_err, rx_overrun, rx_valid, tx_busy, tx_empty, tx_full}
//              write bit4 clears rx_overrun, bit5 clears rx_frame_err
module io_uart #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [14:0] BASE_ADDR    = 15'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] io_address,
  input  logic [15:0] io_write_value,
  input  logic        io_write_en,
  input  logic        io_read_en,
  output logic [15:0] io_read_value,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic sel_data;
  logic sel_status;
  logic push;
  logic data_pop;
  logic status_wr;

  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_count;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_pop;

  tx_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_bit_end;

  logic        rx_meta;
  logic        rx_sync;
  rx_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_done;
  logic        rx_done_ok;
  logic        rx_done_bad;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_overrun;
  logic        rx_frame_err;

  logic        unused_bits;

  assign unused_bits = ^{io_address[15], io_write_value[15:8]};

  assign sel_data   = (io_address[14:0] == BASE_ADDR);
  assign sel_status = (io_address[14:0] == (BASE_ADDR + 15'd1));
  assign status_wr  = io_write_en & sel_status;
  assign data_pop   = io_read_en & sel_data;

  assign tx_full  = (fifo_count == 3'd4);
  assign tx_empty = (fifo_count == 3'd0);
  // Fullness is judged on the pre-edge count, so a write into a full FIFO
  // is dropped even when the shifter pops at the same edge.
  assign push     = io_write_en & sel_data & ~tx_full;

  assign tx_bit_end = (tx_cnt == BIT_LAST);
  // The shifter takes a byte either from idle or straight out of a finishing
  // stop bit, which keeps queued frames contiguous on the wire.
  assign tx_pop = ~tx_empty &
                  ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_bit_end));

  assign rx_done     = (rx_state == RX_STOP) & (rx_cnt == BIT_LAST);
  assign rx_done_ok  = rx_done & rx_sync;
  assign rx_done_bad = rx_done & ~rx_sync;

  // Transmit FIFO storage and pointers; push and pop may share an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'h00;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= io_write_value[7:0];
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (tx_pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + {2'b00, push} - {2'b00, tx_pop};
    end
  end

  // Transmit shifter. uart_tx is a register with asynchronous preset so a
  // reset mid-frame returns the line high without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            tx_cnt   <= '0;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            uart_tx  <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= fifo_mem[rd_ptr];
              uart_tx  <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // Receive deserialiser: the start bit is re-checked at its midpoint, after
  // which every later sample lands one full bit period on, i.e. mid-bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Receive holding register and error flags. A DATA read at the same edge
  // as a completed frame frees the register, so the new byte loads without
  // an overrun. Flag sets take priority over software clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_done_ok && (!rx_valid || data_pop)) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (data_pop) begin
        rx_valid <= 1'b0;
      end
      if (status_wr && io_write_value[4]) rx_overrun <= 1'b0;
      if (rx_done_ok && rx_valid && !data_pop) rx_overrun <= 1'b1;
      if (status_wr && io_write_value[5]) rx_frame_err <= 1'b0;
      if (rx_done_bad) rx_frame_err <= 1'b1;
    end
  end

  // Combinational read mux so single-cycle loads see data in the same cycle.
  always_comb begin
    io_read_value = 16'h0000;
    if (sel_data) begin
      io_read_value = {8'h00, rx_data};
    end else if (sel_status) begin
      io_read_value = {10'b0, rx_frame_err, rx_overrun, rx_valid,
                       (tx_state != TX_IDLE), tx_empty, tx_full};
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// tb_io_uart: directed self-checking bench for io_uart with CLKS_PER_BIT=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_io_uart;

  logic        clk;
  logic        reset;
  logic [15:0] io_address;
  logic [15:0] io_write_value;
  logic        io_write_en;
  logic        io_read_en;
  logic [15:0] io_read_value;
  logic        uart_tx;
  logic        uart_rx;

  int checks;
  int fails;

  io_uart #(
    .CLKS_PER_BIT(4),
    .BASE_ADDR(15'h0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io_address(io_address),
    .io_write_value(io_write_value),
    .io_write_en(io_write_en),
    .io_read_en(io_read_en),
    .io_read_value(io_read_value),
    .uart_tx(uart_tx),
    .uart_rx(uart_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level for each of the 40 cycles of a frame, cycle 0 first.
  function automatic logic [39:0] frame_bits(input logic [7:0] b);
    logic [39:0] f;
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       f[i] = 1'b0;
      else if (i < 36) f[i] = b[(i - 4) / 4];
      else             f[i] = 1'b1;
    end
    return f;
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    io_address     = a;
    io_write_value = v;
    io_write_en    = 1'b1;
    @(negedge clk);
    io_write_en    = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] v);
    io_address = a;
    #1;
    v = io_read_value;
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0)      uart_rx = 1'b0;
      else if (i == 9) uart_rx = stop_bit;
      else             uart_rx = b[i - 1];
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [15:0] v;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_tx: got %b expected 1", uart_tx);
    end
    peek(16'h0001, v);
    checks++;
    if (v !== 16'h0002) begin
      fails++;
      $display("[TB] FAIL reset_status: got %h expected 0002", v);
    end
    peek(16'h0002, v);
    checks++;
    if (v !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset_unmapped: got %h expected 0000", v);
    end
    peek(16'h0000, v);
    checks++;
    if (v !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL reset_data: got %h expected 0000", v);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_tx;
    logic [39:0] got;
    logic [15:0] v;
    logic [15:0] st1;
    logic [15:0] st40;
    bus_write(16'h0000, 16'h00A5);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      got[i - 1] = uart_tx;
      if (i == 1)  peek(16'h0001, st1);
      if (i == 40) peek(16'h0001, st40);
    end
    checks++;
    if (got !== frame_bits(8'hA5)) begin
      fails++;
      $display("[TB] FAIL tx_a5_frame: got %h expected %h", got, frame_bits(8'hA5));
    end
    checks++;
    if (st1 !== 16'h0006) begin
      fails++;
      $display("[TB] FAIL tx_status_after_pop: got %h expected 0006", st1);
    end
    checks++;
    if (st40 !== 16'h0006) begin
      fails++;
      $display("[TB] FAIL tx_busy_in_stop: got %h expected 0006", st40);
    end
    @(negedge clk);
    peek(16'h0001, v);
    checks++;
    if (v !== 16'h0002) begin
      fails++;
      $display("[TB] FAIL tx_busy_drop: got %h expected 0002", v);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic        tx_log [230];
    logic [39:0] got;
    logic [15:0] st_full;
    logic [15:0] st_end;
    logic        tail_ok;
    for (int c = 0; c < 230; c++) begin
      @(negedge clk);
      tx_log[c] = uart_tx;
      if (c < 6) begin
        io_address     = 16'h0000;
        io_write_value = 16'(c + 1);
        io_write_en    = 1'b1;
      end else begin
        io_write_en = 1'b0;
      end
      if (c == 6)   peek(16'h0001, st_full);
      if (c == 202) peek(16'h0001, st_end);
    end
    checks++;
    if (st_full !== 16'h0005) begin
      fails++;
      $display("[TB] FAIL b2b_full: got %h expected 0005", st_full);
    end
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 40; i++) got[i] = tx_log[2 + 40 * f + i];
      checks++;
      if (got !== frame_bits(8'(f + 1))) begin
        fails++;
        $display("[TB] FAIL b2b_frame%0d: got %h expected %h", f + 1, got,
                 frame_bits(8'(f + 1)));
      end
    end
    tail_ok = 1'b1;
    for (int c = 202; c < 230; c++) if (tx_log[c] !== 1'b1) tail_ok = 1'b0;
    checks++;
    if (tail_ok !== 1'b1) begin
      fails++;
      $display("[TB] FAIL b2b_no_sixth_frame: got line activity expected idle high");
    end
    checks++;
    if (st_end !== 16'h0002) begin
      fails++;
      $display("[TB] FAIL b2b_end_status: got %h expected 0002", st_end);
    end
  endtask

  task automatic test_ignored_write;
    logic [15:0] v;
    bus_write(16'h0003, 16'h0055);
    repeat (3) @(negedge clk);
    peek(16'h0001, v);
    checks++;
    if (v !== 16'h0002 || uart_tx !== 1'b1) begin
      fails++;
      $display("[TB] FAIL unmapped_write: got status %h tx %b expected 0002 tx 1",
               v, uart_tx);
    end
  endtask

  task automatic test_rx_basic;
    logic [15:0] v;
    send_rx_frame(8'h3C, 1'b1);
    peek(16'h0001, v);
    checks++;
    if (v !== 16'h000A) begin
      fails++;
      $display("[TB] FAIL rx_valid_status: got %h expected 000A", v);
    end
    io_address = 16'h0000;
    io_read_en = 1'b1;
    #1;
    v = io_read_value;
    checks++;
    if (v !== 16'h003C) begin
      fails++;
      $display("[TB] FAIL rx_data_3c: got %h expected 003C", v);
    end
    @(negedge clk);
    io_read_en = 1'b0;
    peek(16'h0001, v);
    checks++;
    if (v !== 16'h0002) begin
      fails++;
      $display("[TB] FAIL rx_valid_cleared: got %h expected 0002", v);
    end
  endtask

  task automatic test_rx_overrun;
    logic [15:0] v;
    send_rx_frame(8'h11, 1'b1);
    send_rx_frame(8'h22, 1'b1);
    peek(16'h0001, v);
    checks++;
    if (v !== 16'h001A) begin
      fails++;
      $display("[TB] FAIL overrun_status: got %h expected 001A", v);
    end
    peek(16'h0000, v);
    checks++;
    if (v !== 16'h0011) begin
      fails++;
      $display("[TB] FAIL overrun_keeps_old: got %h expected 0011", v);
    end
    bus_write(16'h0001, 16'h0010);
    peek(16'h0001, v);
    checks++;
    if (v !== 16'h000A) begin
      fails++;
      $display("[TB] FAIL overrun_clear: got %h expected 000A", v);
    end
    io_address = 16'h0000;
    io_read_en = 1'b1;
    @(negedge clk);
    io_read_en = 1'b0;
  endtask

  task automatic test_frame_err;
    logic [15:0] v;
    send_rx_frame(8'h5A, 1'b1);
    send_rx_frame(8'h77, 1'b0);
    peek(16'h0001, v);
    checks++;
    if (v !== 16'h002A) begin
      fails++;
      $display("[TB] FAIL frame_err_status: got %h expected 002A", v);
    end
    peek(16'h0000, v);
    checks++;
    if (v !== 16'h005A) begin
      fails++;
      $display("[TB] FAIL frame_err_data_kept: got %h expected 005A", v);
    end
    bus_write(16'h0001, 16'h0020);
    peek(16'h0001, v);
    checks++;
    if (v !== 16'h000A) begin
      fails++;
      $display("[TB] FAIL frame_err_clear: got %h expected 000A", v);
    end
    io_address = 16'h0000;
    io_read_en = 1'b1;
    @(negedge clk);
    io_read_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] v;
    logic        mid_tx;
    logic        idle_ok;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (c < 3) begin
        io_address     = 16'h0000;
        io_write_value = 16'h0000;
        io_write_en    = 1'b1;
      end else begin
        io_write_en = 1'b0;
      end
    end
    mid_tx = uart_tx;
    checks++;
    if (mid_tx !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_frame_low: got %b expected 0", mid_tx);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin
      fails++;
      $display("[TB] FAIL async_reset_tx: got %b expected 1", uart_tx);
    end
    peek(16'h0001, v);
    checks++;
    if (v !== 16'h0002) begin
      fails++;
      $display("[TB] FAIL async_reset_status: got %h expected 0002", v);
    end
    @(negedge clk);
    reset = 1'b0;
    idle_ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) idle_ok = 1'b0;
    end
    checks++;
    if (idle_ok !== 1'b1) begin
      fails++;
      $display("[TB] FAIL no_frames_after_reset: got line activity expected idle high");
    end
    peek(16'h0001, v);
    checks++;
    if (v !== 16'h0002) begin
      fails++;
      $display("[TB] FAIL post_reset_status: got %h expected 0002", v);
    end
  endtask

  initial begin
    checks         = 0;
    fails          = 0;
    reset          = 1'b1;
    io_address     = 16'h0000;
    io_write_value = 16'h0000;
    io_write_en    = 1'b0;
    io_read_en     = 1'b0;
    uart_rx        = 1'b1;
    $display("[TB] io_uart bench start");
    test_reset;
    test_single_tx;
    test_back_to_back;
    test_ignored_write;
    test_rx_basic;
    test_rx_overrun;
    test_frame_err;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
